// File: rtl/acl_pkg.sv
// Shared constants and types for the ADXL362-style SPI responder.
// Instruction codes, register addresses, reset defaults and FSM states.
package acl_pkg;

  localparam logic [7:0] INS_WRITE = 8'h0A;
  localparam logic [7:0] INS_READ  = 8'h0B;

  localparam logic [5:0] REG_DEVID_AD   = 6'h00;
  localparam logic [5:0] REG_DEVID_MST  = 6'h01;
  localparam logic [5:0] REG_PARTID     = 6'h02;
  localparam logic [5:0] REG_STATUS     = 6'h0B;
  localparam logic [5:0] REG_XDATA_L    = 6'h0E;
  localparam logic [5:0] REG_XDATA_H    = 6'h0F;
  localparam logic [5:0] REG_YDATA_L    = 6'h10;
  localparam logic [5:0] REG_YDATA_H    = 6'h11;
  localparam logic [5:0] REG_ZDATA_L    = 6'h12;
  localparam logic [5:0] REG_ZDATA_H    = 6'h13;
  localparam logic [5:0] REG_SOFT_RESET = 6'h1F;
  localparam logic [5:0] REG_FILTER_CTL = 6'h2C;
  localparam logic [5:0] REG_POWER_CTL  = 6'h2D;

  localparam logic [7:0] FILTER_CTL_RST = 8'h13;
  localparam logic [7:0] POWER_CTL_RST  = 8'h00;
  localparam logic [7:0] SOFT_RESET_KEY = 8'h52;

  typedef enum logic [2:0] {
    S_IDLE,
    S_INS,
    S_ADDR,
    S_WDAT,
    S_RDAT,
    S_DROP
  } state_t;

  // High data byte: sign-extended upper nibble of a 12-bit sample
  function automatic logic [7:0] data_h(input logic [11:0] s);
    return {{4{s[11]}}, s[11:8]};
  endfunction

endpackage

// File: rtl/spi_slave_shifter.sv
// SPI mode-0 slave bit engine: pin synchronizers, edge detect,
// bit counter, RX/TX shift registers and MISO drive.
module spi_slave_shifter #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       sclk,
  input  logic       mosi,
  input  logic       cs,
  input  logic       tx_en,
  input  logic       tx_load,
  input  logic [7:0] tx_byte,
  output logic       byte_strobe,
  output logic [7:0] rx_byte,
  output logic       cs_fall,
  output logic       cs_rise,
  output logic       cs_low,
  output logic       miso
);

  logic [SYNC_STAGES-1:0] sclk_sync, mosi_sync, cs_sync;
  logic       sclk_d, cs_d;
  logic       sclk_q, mosi_q, cs_q;
  logic       sclk_rise, sclk_fall;
  logic [2:0] bit_cnt;
  logic [6:0] rx_sh;
  logic [7:0] tx_sh;

  assign sclk_q    = sclk_sync[SYNC_STAGES-1];
  assign mosi_q    = mosi_sync[SYNC_STAGES-1];
  assign cs_q      = cs_sync[SYNC_STAGES-1];
  assign sclk_rise = sclk_q & ~sclk_d;
  assign sclk_fall = ~sclk_q & sclk_d;
  assign cs_rise   = cs_q & ~cs_d;
  assign cs_fall   = ~cs_q & cs_d;
  assign cs_low    = ~cs_q;

  // CS syncs to low at reset so a frame already open is never entered
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      sclk_sync <= '0;
      mosi_sync <= '0;
      cs_sync   <= '0;
      sclk_d    <= 1'b0;
      cs_d      <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs};
      sclk_d    <= sclk_q;
      cs_d      <= cs_q;
    end
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      bit_cnt <= 3'd0;
      rx_sh   <= 7'd0;
    end else if (cs_fall || cs_rise) begin
      bit_cnt <= 3'd0;
    end else if (cs_low && sclk_rise) begin
      bit_cnt <= bit_cnt + 3'd1;
      rx_sh   <= {rx_sh[5:0], mosi_q};
    end
  end

  // No shift at count 0: keeps the freshly loaded MSB for the next rise
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      tx_sh <= 8'd0;
    end else if (tx_load) begin
      tx_sh <= tx_byte;
    end else if (cs_low && sclk_fall && bit_cnt != 3'd0) begin
      tx_sh <= {tx_sh[6:0], 1'b0};
    end
  end

  assign byte_strobe = cs_low & sclk_rise & (bit_cnt == 3'd7);
  assign rx_byte     = {rx_sh, mosi_q};
  assign miso        = tx_en & cs_low & tx_sh[7];

endmodule

// File: rtl/acl_spi_responder.sv
// ADXL362-style accelerometer register responder on SPI:
// instruction/address/data protocol, register file, sample snapshot.
module acl_spi_responder #(
  parameter logic [7:0] DEVID_AD    = 8'hAD,
  parameter logic [7:0] DEVID_MST   = 8'h1D,
  parameter logic [7:0] PARTID      = 8'hF2,
  parameter int         SYNC_STAGES = 2
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        SCLK,
  input  logic        MOSI,
  input  logic        CS,
  output logic        MISO,
  input  logic        sample_valid,
  input  logic [11:0] sample_x,
  input  logic [11:0] sample_y,
  input  logic [11:0] sample_z,
  output logic [7:0]  power_ctl,
  output logic        measuring,
  output logic        txn_done
);

  import acl_pkg::*;

  state_t      state, state_n;
  logic        byte_strobe, cs_fall, cs_rise, cs_low;
  logic        tx_en, tx_load;
  logic [7:0]  rx_byte, tx_byte, filter_ctl;
  logic [5:0]  addr, tx_addr;
  logic        is_read, byte_seen, data_hit;
  logic        do_write, soft_rst;
  logic        status, status_n, pend_valid, apply;
  logic [11:0] data_x, data_y, data_z;
  logic [11:0] pend_x, pend_y, pend_z;

  assign tx_en = (state == S_RDAT);

  spi_slave_shifter #(.SYNC_STAGES(SYNC_STAGES)) u_shifter (
    .Clock       (Clock),
    .Reset       (Reset),
    .sclk        (SCLK),
    .mosi        (MOSI),
    .cs          (CS),
    .tx_en       (tx_en),
    .tx_load     (tx_load),
    .tx_byte     (tx_byte),
    .byte_strobe (byte_strobe),
    .rx_byte     (rx_byte),
    .cs_fall     (cs_fall),
    .cs_rise     (cs_rise),
    .cs_low      (cs_low),
    .miso        (MISO)
  );

  always_comb begin
    state_n  = state;
    tx_load  = 1'b0;
    tx_addr  = addr + 6'd1;
    do_write = 1'b0;
    if (cs_rise) begin
      state_n = S_IDLE;
    end else begin
      unique case (state)
        S_IDLE: if (cs_fall) state_n = S_INS;
        S_INS: if (byte_strobe) begin
          if (rx_byte == INS_WRITE || rx_byte == INS_READ)
            state_n = S_ADDR;
          else
            state_n = S_DROP;
        end
        S_ADDR: if (byte_strobe) begin
          state_n = is_read ? S_RDAT : S_WDAT;
          tx_load = is_read;
          tx_addr = rx_byte[5:0];
        end
        S_WDAT: do_write = byte_strobe;
        S_RDAT: tx_load = byte_strobe;
        S_DROP: ;
        default: state_n = S_IDLE;
      endcase
    end
  end

  always_comb begin
    case (tx_addr)
      REG_DEVID_AD:   tx_byte = DEVID_AD;
      REG_DEVID_MST:  tx_byte = DEVID_MST;
      REG_PARTID:     tx_byte = PARTID;
      REG_STATUS:     tx_byte = {7'd0, status};
      REG_XDATA_L:    tx_byte = data_x[7:0];
      REG_XDATA_H:    tx_byte = data_h(data_x);
      REG_YDATA_L:    tx_byte = data_y[7:0];
      REG_YDATA_H:    tx_byte = data_h(data_y);
      REG_ZDATA_L:    tx_byte = data_z[7:0];
      REG_ZDATA_H:    tx_byte = data_h(data_z);
      REG_FILTER_CTL: tx_byte = filter_ctl;
      REG_POWER_CTL:  tx_byte = power_ctl;
      default:        tx_byte = 8'h00;
    endcase
  end

  assign soft_rst = do_write && addr == REG_SOFT_RESET &&
                    rx_byte == SOFT_RESET_KEY;
  // Samples land outside frames; a pending one lands on the CS rise
  assign apply = (sample_valid && !cs_low) || (cs_rise && pend_valid);

  always_comb begin
    status_n = status;
    if (soft_rst) status_n = 1'b0;
    if (cs_rise && data_hit) status_n = 1'b0;
    if (apply) status_n = 1'b1;
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) state <= S_IDLE;
    else        state <= state_n;
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      addr      <= 6'd0;
      is_read   <= 1'b0;
      byte_seen <= 1'b0;
      data_hit  <= 1'b0;
      txn_done  <= 1'b0;
    end else begin
      txn_done <= cs_rise && byte_seen;
      if (state == S_INS && byte_strobe)
        is_read <= (rx_byte == INS_READ);
      if (state == S_ADDR && byte_strobe)
        addr <= rx_byte[5:0];
      else if (byte_strobe && (state == S_WDAT || state == S_RDAT))
        addr <= addr + 6'd1;
      if (cs_fall || cs_rise)
        byte_seen <= 1'b0;
      else if (byte_strobe && state != S_IDLE)
        byte_seen <= 1'b1;
      if (cs_fall || cs_rise)
        data_hit <= 1'b0;
      else if (byte_strobe && state == S_RDAT &&
               addr >= REG_XDATA_L && addr <= REG_ZDATA_H)
        data_hit <= 1'b1;
    end
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      power_ctl  <= POWER_CTL_RST;
      filter_ctl <= FILTER_CTL_RST;
    end else if (do_write) begin
      unique case (1'b1)
        soft_rst: begin
          power_ctl  <= POWER_CTL_RST;
          filter_ctl <= FILTER_CTL_RST;
        end
        addr == REG_FILTER_CTL: filter_ctl <= rx_byte;
        addr == REG_POWER_CTL:  power_ctl  <= rx_byte;
        default: ;
      endcase
    end
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      status     <= 1'b0;
      pend_valid <= 1'b0;
      pend_x     <= '0;
      pend_y     <= '0;
      pend_z     <= '0;
      data_x     <= '0;
      data_y     <= '0;
      data_z     <= '0;
    end else begin
      status <= status_n;
      if (sample_valid && cs_low) begin
        pend_valid <= 1'b1;
        pend_x     <= sample_x;
        pend_y     <= sample_y;
        pend_z     <= sample_z;
      end else if (cs_rise) begin
        pend_valid <= 1'b0;
      end
      if (apply) begin
        data_x <= sample_valid ? sample_x : pend_x;
        data_y <= sample_valid ? sample_y : pend_y;
        data_z <= sample_valid ? sample_z : pend_z;
      end
    end
  end

  assign measuring = (power_ctl[1:0] == 2'b10);

endmodule

// File: tb/tb_acl_spi_responder.sv
// Self-checking bench for acl_spi_responder: SPI master driver,
// transaction-level register model and per-cycle output compare.
module tb_acl_spi_responder;

  logic        Clock = 1'b0;
  logic        Reset = 1'b0;
  logic        SCLK = 1'b0;
  logic        MOSI = 1'b0;
  logic        CS = 1'b1;
  logic        MISO;
  logic        sample_valid = 1'b0;
  logic [11:0] sample_x = '0;
  logic [11:0] sample_y = '0;
  logic [11:0] sample_z = '0;
  logic [7:0]  power_ctl;
  logic        measuring;
  logic        txn_done;

  acl_spi_responder dut (
    .Clock        (Clock),
    .Reset        (Reset),
    .SCLK         (SCLK),
    .MOSI         (MOSI),
    .CS           (CS),
    .MISO         (MISO),
    .sample_valid (sample_valid),
    .sample_x     (sample_x),
    .sample_y     (sample_y),
    .sample_z     (sample_z),
    .power_ctl    (power_ctl),
    .measuring    (measuring),
    .txn_done     (txn_done)
  );

  always #5 Clock = ~Clock;

  int n_cmp = 0;
  int n_bad = 0;
  int txn_cnt = 0;
  bit in_frame = 1'b1;
  bit zero_chk = 1'b0;

  logic [7:0] tq [16];
  logic [7:0] rq [16];

  // Register-map model
  logic [7:0]  m_power, m_filter;
  logic [11:0] m_x, m_y, m_z;
  logic        m_status;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic clocks(input int n);
    repeat (n) @(negedge Clock);
  endtask

  task automatic model_reset();
    m_power  = 8'h00;
    m_filter = 8'h13;
    m_x = '0;
    m_y = '0;
    m_z = '0;
    m_status = 1'b0;
  endtask

  function automatic logic [7:0] hi(input logic [11:0] s);
    return {{4{s[11]}}, s[11:8]};
  endfunction

  function automatic logic [7:0] mrd(input logic [5:0] a);
    case (a)
      6'h00: return 8'hAD;
      6'h01: return 8'h1D;
      6'h02: return 8'hF2;
      6'h0B: return {7'd0, m_status};
      6'h0E: return m_x[7:0];
      6'h0F: return hi(m_x);
      6'h10: return m_y[7:0];
      6'h11: return hi(m_y);
      6'h12: return m_z[7:0];
      6'h13: return hi(m_z);
      6'h2C: return m_filter;
      6'h2D: return m_power;
      default: return 8'h00;
    endcase
  endfunction

  task automatic mwr(input logic [5:0] a, input logic [7:0] d);
    if (a == 6'h2C) m_filter = d;
    if (a == 6'h2D) m_power = d;
    if (a == 6'h1F && d == 8'h52) begin
      m_power = 8'h00;
      m_filter = 8'h13;
      m_status = 1'b0;
    end
  endtask

  // Reads use pre-frame state; pending sample lands after status clear
  task automatic model_frame(input int nbytes, input bit pend);
    logic [5:0] a;
    bit hit;
    hit = 1'b0;
    if (nbytes >= 2 && (tq[0] == 8'h0A || tq[0] == 8'h0B)) begin
      a = tq[1][5:0];
      for (int i = 2; i < nbytes; i++) begin
        if (tq[0] == 8'h0B) begin
          check($sformatf("read_%02h", a), rq[i], mrd(a));
          if (a >= 6'h0E && a <= 6'h13) hit = 1'b1;
        end else begin
          mwr(a, tq[i]);
        end
        a = a + 6'd1;
      end
    end
    if (hit) m_status = 1'b0;
    if (pend) begin
      m_x = sample_x;
      m_y = sample_y;
      m_z = sample_z;
      m_status = 1'b1;
    end
  endtask

  task automatic shift(input int total, input int sbit);
    for (int k = 0; k < total; k++) begin
      MOSI = tq[k/8][7-k%8];
      if (k == sbit) begin
        sample_valid = 1'b1;
        clocks(1);
        sample_valid = 1'b0;
        clocks(3);
      end else begin
        clocks(4);
      end
      rq[k/8][7-k%8] = MISO;
      SCLK = 1'b1;
      clocks(4);
      SCLK = 1'b0;
    end
  endtask

  task automatic frame(input int nbytes, input int xbits, input int sbit);
    int total;
    int t0;
    total = nbytes * 8 + xbits;
    in_frame = 1'b1;
    zero_chk = !(nbytes >= 2 && tq[0] == 8'h0B);
    for (int i = 0; i < 16; i++) rq[i] = 8'h00;
    t0 = txn_cnt;
    CS = 1'b0;
    clocks(4);
    shift(total, sbit);
    clocks(4);
    CS = 1'b1;
    MOSI = 1'b0;
    clocks(8);
    check("txn_done_count", txn_cnt - t0, (nbytes > 0) ? 1 : 0);
    model_frame(nbytes, sbit >= 0 && sbit < total);
    zero_chk = 1'b0;
    in_frame = 1'b0;
    clocks(2);
  endtask

  task automatic write_reg(input logic [7:0] a, input logic [7:0] d);
    tq[0] = 8'h0A;
    tq[1] = a;
    tq[2] = d;
    frame(3, 0, -1);
  endtask

  task automatic read_burst(input logic [7:0] a, input int n);
    tq[0] = 8'h0B;
    tq[1] = a;
    for (int i = 2; i < 16; i++) tq[i] = 8'h00;
    frame(n + 2, 0, -1);
  endtask

  task automatic apply_sample(input logic [11:0] x, input logic [11:0] y,
                              input logic [11:0] z);
    sample_x = x;
    sample_y = y;
    sample_z = z;
    sample_valid = 1'b1;
    clocks(1);
    sample_valid = 1'b0;
    clocks(3);
    m_x = x;
    m_y = y;
    m_z = z;
    m_status = 1'b1;
  endtask

  always @(negedge Clock) begin
    if (txn_done === 1'b1) txn_cnt++;
    if (zero_chk) check("miso_quiet", MISO, 0);
    if (!in_frame) begin
      check("power_ctl", power_ctl, m_power);
      check("measuring", measuring, m_power[1:0] == 2'b10);
      check("txn_idle", txn_done, 0);
      check("miso_idle", MISO, 0);
    end
  end

  initial begin
    int t0;
    model_reset();
    clocks(3);
    check("rst_miso", MISO, 0);
    check("rst_power", power_ctl, 8'h00);
    check("rst_measuring", measuring, 0);
    check("rst_txn", txn_done, 0);
    Reset = 1'b1;
    clocks(6);
    in_frame = 1'b0;
    clocks(4);

    // ID registers
    tq[0] = 8'h0B;
    for (int i = 1; i < 16; i++) tq[i] = 8'h00;
    frame(5, 0, -1);
    check("lit_devid_ad", rq[2], 8'hAD);
    check("lit_devid_mst", rq[3], 8'h1D);
    check("lit_partid", rq[4], 8'hF2);

    // POWER_CTL write/read and soft reset
    write_reg(8'h2D, 8'h02);
    check("lit_power_02", power_ctl, 8'h02);
    check("lit_measuring_1", measuring, 1);
    read_burst(8'h2D, 1);
    check("lit_read_power", rq[2], 8'h02);
    write_reg(8'h2C, 8'h55);
    read_burst(8'h2C, 1);
    check("lit_filter_55", rq[2], 8'h55);
    write_reg(8'h1F, 8'h52);
    check("lit_power_sr", power_ctl, 8'h00);
    check("lit_measuring_0", measuring, 0);
    read_burst(8'h2C, 1);
    check("lit_filter_sr", rq[2], 8'h13);

    // Sample with CS high, STATUS set/clear
    apply_sample(12'h123, 12'hF80, 12'h7FF);
    read_burst(8'h0B, 1);
    check("lit_status_set", rq[2], 8'h01);
    read_burst(8'h0E, 6);
    check("lit_xl", rq[2], 8'h23);
    check("lit_xh", rq[3], 8'h01);
    check("lit_yl", rq[4], 8'h80);
    check("lit_yh", rq[5], 8'hFF);
    check("lit_zl", rq[6], 8'hFF);
    check("lit_zh", rq[7], 8'h07);
    read_burst(8'h0B, 1);
    check("lit_status_clr", rq[2], 8'h00);

    // Sample strobed mid-burst stays pending until CS rise
    sample_x = 12'h001;
    sample_y = 12'h000;
    sample_z = 12'h000;
    tq[0] = 8'h0B;
    tq[1] = 8'h0E;
    tq[2] = 8'h00;
    tq[3] = 8'h00;
    frame(4, 0, 20);
    check("lit_mid_xl", rq[2], 8'h23);
    check("lit_mid_xh", rq[3], 8'h01);
    read_burst(8'h0B, 5);
    check("lit_pend_status", rq[2], 8'h01);
    check("lit_pend_xl", rq[5], 8'h01);
    check("lit_pend_xh", rq[6], 8'h00);

    // Address wrap and dropped instruction
    read_burst(8'h3F, 2);
    check("lit_wrap_3f", rq[2], 8'h00);
    check("lit_wrap_00", rq[3], 8'hAD);
    tq[0] = 8'h0D;
    tq[1] = 8'h2D;
    tq[2] = 8'h02;
    frame(3, 0, -1);
    write_reg(8'h00, 8'h77);
    read_burst(8'h00, 1);
    check("lit_ro_id", rq[2], 8'hAD);

    // Partial bytes
    tq[0] = 8'h0A;
    tq[1] = 8'h2C;
    tq[2] = 8'hFF;
    frame(2, 5, -1);
    frame(0, 5, -1);
    read_burst(8'h2C, 1);
    check("lit_filter_partial", rq[2], 8'h13);

    // Reset in the middle of a read, CS held low across release
    write_reg(8'h2D, 8'h02);
    in_frame = 1'b1;
    tq[0] = 8'h0B;
    tq[1] = 8'h02;
    CS = 1'b0;
    clocks(4);
    shift(16, -1);
    MOSI = 1'b0;
    clocks(4);
    check("lit_miso_msb", MISO, 1);
    Reset = 1'b0;
    #1;
    check("rst_mid_miso", MISO, 0);
    check("rst_mid_power", power_ctl, 8'h00);
    check("rst_mid_measuring", measuring, 0);
    check("rst_mid_txn", txn_done, 0);
    model_reset();
    clocks(3);
    Reset = 1'b1;
    clocks(2);
    zero_chk = 1'b1;
    t0 = txn_cnt;
    tq[0] = 8'h0B;
    tq[1] = 8'h2D;
    shift(16, -1);
    clocks(4);
    CS = 1'b1;
    clocks(8);
    check("txn_after_reset", txn_cnt - t0, 0);
    zero_chk = 1'b0;
    in_frame = 1'b0;
    clocks(2);
    read_burst(8'h2C, 1);
    check("lit_filter_rst", rq[2], 8'h13);
    read_burst(8'h0E, 2);
    check("lit_xl_rst", rq[2], 8'h00);
    check("lit_xh_rst", rq[3], 8'h00);
    read_burst(8'h2D, 1);
    check("lit_power_rst", rq[2], 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/acl_spi_responder.md
Name: acl_spi_responder

Overview:
- Synthesizable SPI slave that emulates the ADXL362-style accelerometer register interface: instruction byte, address byte, then data bytes with address auto-increment.
- Sits on SCLK/MOSI/MISO/CS in place of the physical sensor, so the alarm datapath can be exercised in simulation and on-board loopback with injected X/Y/Z samples.
- Serves the write-register (0x0A) and read-register (0x0B) transactions the accelerometer driver issues.

Parameters:
- DEVID_AD, 8'hAD, read value of reg 0x00
- DEVID_MST, 8'h1D, read value of reg 0x01
- PARTID, 8'hF2, read value of reg 0x02
- SYNC_STAGES, 2, synchronizer depth for SCLK/MOSI/CS (minimum 2)

Ports:
- Clock  in  1  system clock; must be at least 8x SCLK frequency
- Reset  in  1  asynchronous, active-low
- SCLK  in  1  SPI clock from master, mode 0 (idle low)
- MOSI  in  1  master-out data, MSB first
- CS  in  1  chip select, active-low
- MISO  out  1  slave-out data, MSB first
- sample_valid  in  1  one-cycle strobe: new X/Y/Z sample present
- sample_x, sample_y, sample_z  in  12 each  signed 12-bit samples
- power_ctl  out  8  current POWER_CTL (0x2D) value
- measuring  out  1  high when power_ctl[1:0] == 2'b10
- txn_done  out  1  one-cycle pulse when CS rises after at least one complete byte

Behaviour:
- Reset: MISO=0, power_ctl=0x00, measuring=0, txn_done=0, filter_ctl=0x13, data regs=0, status=0, FSM=S_IDLE, bit counter=0, address=0.
- CS, SCLK and MOSI pass through SYNC_STAGES flops, then edge detection. MOSI is sampled on the synced SCLK rising edge. MISO shifts on the synced SCLK falling edge. MISO updates within SYNC_STAGES+1 Clock cycles of the pin edge.
- 3-bit bit counter, cleared on CS falling edge. A byte is complete on the 8th rising edge, which raises an internal byte strobe and wraps the counter to 0.
- FSM states and transitions:
  - S_IDLE: CS fall -> S_INS.
  - S_INS: on byte, 0x0A -> S_ADDR (write), 0x0B -> S_ADDR (read), anything else -> S_DROP.
  - S_ADDR: on byte, latch addr[5:0] (bits 7:6 ignored). Write -> S_WDAT. Read -> S_RDAT, and load the TX shift register with reg[addr].
  - S_WDAT: on each byte, write reg[addr] if writable, then addr = addr+1.
  - S_RDAT: on each byte, addr = addr+1, then load the TX register with reg[new addr].
  - S_DROP: ignore all traffic; MISO=0.
  - Any state: CS rise -> S_IDLE.
- MISO: equals TX[7] while CS is low in S_RDAT, otherwise 0. The falling edge with bit counter==0 does not shift, so the MSB of the loaded byte is preserved for the first rising edge.
- Address wraps 0x3F -> 0x00.
- Register map:
  - 0x00-0x02: ID, read-only.
  - 0x0B STATUS: bit0 = DATA_READY, read-only.
  - 0x0E/0x0F XDATA_L/H, 0x10/0x11 YDATA_L/H, 0x12/0x13 ZDATA_L/H. L = sample[7:0]; H = {4x sample[11], sample[11:8]}.
  - 0x1F SOFT_RESET: write-only; writing 0x52 restores power_ctl and filter_ctl to defaults and clears status. Other values are ignored. Reads 0x00.
  - 0x2C FILTER_CTL and 0x2D POWER_CTL: read/write.
  - All other addresses read 0x00; writes to them are ignored.
- Sample coherency:
  - sample_valid with CS high: data regs update next cycle and STATUS[0] is set.
  - sample_valid with CS low: sample is held pending (latest wins) and applied on the CS rise cycle.
  - sample_valid coincident with CS rise: that sample is applied.
- STATUS[0] clears on the CS rise of any read burst that transferred a complete byte from 0x0E-0x13. If a pending sample is applied on that same cycle, set wins.
- CS rise mid-byte: partial byte discarded, no register write, bit counter cleared.
- txn_done pulses only if at least one complete byte was received in the frame.
- Reset mid-transaction returns everything to reset values immediately. The next frame starts only after a fresh CS falling edge; CS already low at reset release is treated as S_DROP until CS rises.

Decomposition:
- Shared package acl_pkg holds:
  - instruction codes INS_WRITE=0x0A, INS_READ=0x0B;
  - register address constants (DEVID_AD, STATUS, XDATA_L through ZDATA_H, SOFT_RESET, FILTER_CTL, POWER_CTL);
  - reset defaults and SOFT_RESET key 0x52;
  - FSM state encoding.
- Natural sub-module spi_slave_shifter contains synchronizers, edge detect, bit counter, RX/TX shift registers and MISO drive. Its interface is: byte strobe plus rx_byte out; tx_load plus tx_byte in; cs_fall/cs_rise pulses.
- Register file, FSM and sample snapshot logic stay in acl_spi_responder.

Test Plan:
- Frame 0B 00 00 00 00, Clock = 8x SCLK -> MISO bytes xx, xx, AD, 1D, F2; txn_done pulses once at CS rise.
- Frame 0A 2D 02, then read 0B 2D 00 -> power_ctl=0x02, measuring=1, read returns 0x02; then write 0A 1F 52 -> power_ctl=0x00, measuring=0.
- sample x=0x123, y=0xF80, z=0x7FF with CS high, then read 0B 0E + 6 bytes -> 23 01 80 FF FF 07; STATUS read before the burst = 0x01, after the CS rise = 0x00.
- Read burst 0B 0E open; sample_valid x=0x001 strobed mid-burst -> burst still returns the old values; the next burst returns 01 00 for XDATA; STATUS=0x01.
- Read starting at 0x3F for 2 bytes -> 00 then AD (address wrap); instruction 0x0D -> MISO=0 for the whole frame, no register changes.
- CS raised after 5 bits of a write data byte to 0x2C -> filter_ctl stays 0x13, no txn_done if the instruction byte was also incomplete; Reset asserted mid-read -> MISO=0 and all outputs at reset values the same cycle.
